// File: rtl/bc_control_unit.sv
// Basic-computer timing and control sequencer.
// Holds the T-state counter and decodes IR into ALU, bus and register strobes.
module bc_control_unit #(
   parameter int ADDR_W = 12
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [15:0] IR,
   input  logic       Z,
   input  logic       N,
   input  logic       E,
   input  logic       DR_Z,
   output logic [2:0] OPSEL,
   output logic [2:0] BUS_SEL,
   output logic       LD_AR,
   output logic       LD_PC,
   output logic       LD_DR,
   output logic       LD_AC,
   output logic       LD_IR,
   output logic       INC_AR,
   output logic       INC_PC,
   output logic       INC_DR,
   output logic       INC_AC,
   output logic       CLR_AC,
   output logic       CLR_E,
   output logic       CMP_E,
   output logic       E_EN,
   output logic       MEM_WR,
   output logic [2:0] SC,
   output logic       HALTED
);

   typedef enum logic [2:0] {
      T0, T1, T2, T3, T4, T5, T6, TX
   } t_e;

   t_e               sc_q, sc_d;
   logic             i_q, i_d;
   logic             halted_q, halted_d;
   logic [7:0]       d;
   logic             d7;
   logic [ADDR_W-1:0] rr;
   logic             skip;

   assign d  = 8'b1 << IR[14:12];
   assign d7 = d[7];
   assign rr = IR[ADDR_W-1:0];

   // Skip tests see the flags of the AC as it stands before this cycle.
   assign skip = (rr[4] & ~N) | (rr[3] & N) |
                 (rr[2] & Z)  | (rr[1] & ~E);

   assign SC     = sc_q;
   assign HALTED = halted_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sc_q     <= T0;
         i_q      <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         sc_q     <= sc_d;
         i_q      <= i_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      OPSEL    = 3'b111;
      BUS_SEL  = 3'd0;
      LD_AR    = 1'b0;
      LD_PC    = 1'b0;
      LD_DR    = 1'b0;
      LD_AC    = 1'b0;
      LD_IR    = 1'b0;
      INC_AR   = 1'b0;
      INC_PC   = 1'b0;
      INC_DR   = 1'b0;
      INC_AC   = 1'b0;
      CLR_AC   = 1'b0;
      CLR_E    = 1'b0;
      CMP_E    = 1'b0;
      E_EN     = 1'b0;
      MEM_WR   = 1'b0;
      sc_d     = t_e'(sc_q + 3'd1);
      i_d      = i_q;
      halted_d = halted_q;

      if (halted_q) begin
         sc_d = T0;
      end else if (RST_N) begin
         unique case (sc_q)
            T0: begin
               BUS_SEL = 3'd2;
               LD_AR   = 1'b1;
            end
            T1: begin
               BUS_SEL = 3'd7;
               LD_IR   = 1'b1;
               INC_PC  = 1'b1;
            end
            T2: begin
               BUS_SEL = 3'd5;
               LD_AR   = 1'b1;
               i_d     = IR[15];
            end
            T3: begin
               if (d7) begin
                  sc_d = T0;
                  if (!i_q) begin
                     CLR_AC = rr[11];
                     CLR_E  = rr[10];
                     CMP_E  = rr[8];
                     INC_AC = rr[5];
                     INC_PC = skip;
                     if (rr[9]) begin
                        OPSEL = 3'b011;
                        LD_AC = 1'b1;
                     end else if (rr[7]) begin
                        OPSEL = 3'b100;
                        LD_AC = 1'b1;
                        E_EN  = 1'b1;
                     end else if (rr[6]) begin
                        OPSEL = 3'b101;
                        LD_AC = 1'b1;
                        E_EN  = 1'b1;
                     end
                     if (rr[11])
                        LD_AC = 1'b0;
                     if (rr[0])
                        halted_d = 1'b1;
                  end
               end else if (i_q) begin
                  BUS_SEL = 3'd7;
                  LD_AR   = 1'b1;
               end
            end
            T4: begin
               unique case (1'b1)
                  d[0], d[1], d[2], d[6]: begin
                     BUS_SEL = 3'd7;
                     LD_DR   = 1'b1;
                  end
                  d[3]: begin
                     BUS_SEL = 3'd4;
                     MEM_WR  = 1'b1;
                     sc_d    = T0;
                  end
                  d[4]: begin
                     BUS_SEL = 3'd1;
                     LD_PC   = 1'b1;
                     sc_d    = T0;
                  end
                  d[5]: begin
                     BUS_SEL = 3'd2;
                     MEM_WR  = 1'b1;
                     INC_AR  = 1'b1;
                  end
                  default: sc_d = T0;
               endcase
            end
            T5: begin
               sc_d = T0;
               unique case (1'b1)
                  d[0]: begin
                     OPSEL = 3'b001;
                     LD_AC = 1'b1;
                  end
                  d[1]: begin
                     OPSEL = 3'b000;
                     LD_AC = 1'b1;
                     E_EN  = 1'b1;
                  end
                  d[2]: begin
                     OPSEL = 3'b010;
                     LD_AC = 1'b1;
                  end
                  d[5]: begin
                     BUS_SEL = 3'd1;
                     LD_PC   = 1'b1;
                  end
                  d[6]: begin
                     INC_DR = 1'b1;
                     sc_d   = T6;
                  end
                  default: sc_d = T0;
               endcase
            end
            T6: begin
               sc_d = T0;
               if (d[6]) begin
                  BUS_SEL = 3'd3;
                  MEM_WR  = 1'b1;
                  INC_PC  = DR_Z;
               end
            end
            default: sc_d = T0;
         endcase
      end
   end

endmodule

// File: tb/tb_bc_control_unit.sv
// Directed-vector bench for bc_control_unit.
// Each check packs HALTED, SC, OPSEL, BUS_SEL and all strobes into one word.
module tb_bc_control_unit;

   logic        CLK;
   logic        RST_N;
   logic [15:0] IR;
   logic        Z, N, E, DR_Z;
   logic [2:0]  OPSEL, BUS_SEL, SC;
   logic        LD_AR, LD_PC, LD_DR, LD_AC, LD_IR;
   logic        INC_AR, INC_PC, INC_DR, INC_AC;
   logic        CLR_AC, CLR_E, CMP_E, E_EN, MEM_WR, HALTED;

   int checks = 0;
   int failures = 0;

   localparam logic [13:0] S_LDAR  = 14'h2000;
   localparam logic [13:0] S_LDPC  = 14'h1000;
   localparam logic [13:0] S_LDDR  = 14'h0800;
   localparam logic [13:0] S_LDAC  = 14'h0400;
   localparam logic [13:0] S_LDIR  = 14'h0200;
   localparam logic [13:0] S_INCAR = 14'h0100;
   localparam logic [13:0] S_INCPC = 14'h0080;
   localparam logic [13:0] S_INCDR = 14'h0040;
   localparam logic [13:0] S_INCAC = 14'h0020;
   localparam logic [13:0] S_CLRAC = 14'h0010;
   localparam logic [13:0] S_CLRE  = 14'h0008;
   localparam logic [13:0] S_CMPE  = 14'h0004;
   localparam logic [13:0] S_EEN   = 14'h0002;
   localparam logic [13:0] S_MEMWR = 14'h0001;

   bc_control_unit #(.ADDR_W(12)) dut (
      .CLK(CLK), .RST_N(RST_N), .IR(IR),
      .Z(Z), .N(N), .E(E), .DR_Z(DR_Z),
      .OPSEL(OPSEL), .BUS_SEL(BUS_SEL),
      .LD_AR(LD_AR), .LD_PC(LD_PC), .LD_DR(LD_DR),
      .LD_AC(LD_AC), .LD_IR(LD_IR),
      .INC_AR(INC_AR), .INC_PC(INC_PC),
      .INC_DR(INC_DR), .INC_AC(INC_AC),
      .CLR_AC(CLR_AC), .CLR_E(CLR_E), .CMP_E(CMP_E),
      .E_EN(E_EN), .MEM_WR(MEM_WR),
      .SC(SC), .HALTED(HALTED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [13:0] strb;
   logic [31:0] obs;
   assign strb = {LD_AR, LD_PC, LD_DR, LD_AC, LD_IR,
                  INC_AR, INC_PC, INC_DR, INC_AC,
                  CLR_AC, CLR_E, CMP_E, E_EN, MEM_WR};
   assign obs = {8'd0, HALTED, SC, OPSEL, BUS_SEL, strb};

   function automatic logic [31:0] v(logic h, logic [2:0] s,
                                     logic [2:0] o, logic [2:0] b,
                                     logic [13:0] st);
      return {8'd0, h, s, o, b, st};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(negedge CLK);
      #1;
   endtask

   task automatic fetch(logic [15:0] ir);
      IR = ir;
      #1;
      chk("t0", obs, v(0, 0, 7, 2, S_LDAR));
      step;
      chk("t1", obs, v(0, 1, 7, 7, S_LDIR | S_INCPC));
      step;
      chk("t2", obs, v(0, 2, 7, 5, S_LDAR));
      step;
   endtask

   task automatic rref(string tag, logic [15:0] ir,
                       logic [2:0] o, logic [13:0] st);
      fetch(ir);
      chk(tag, obs, v(0, 3, o, 0, st));
      step;
      chk("rr_end", obs, v(0, 0, 7, 2, S_LDAR));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0;
      IR = 16'h0;
      Z = 0; N = 0; E = 0; DR_Z = 0;
      repeat (2) @(posedge CLK);
      step;
      chk("reset", obs, v(0, 0, 7, 0, 14'h0));
      RST_N = 1'b1;

      // ADD direct
      fetch(16'h1123);
      chk("add_t3", obs, v(0, 3, 7, 0, 14'h0));
      step;
      chk("add_t4", obs, v(0, 4, 7, 7, S_LDDR));
      step;
      chk("add_t5", obs, v(0, 5, 0, 0, S_LDAC | S_EEN));
      step;
      chk("add_end", SC, 0);

      // LDA indirect
      fetch(16'hA050);
      chk("lda_t3", obs, v(0, 3, 7, 7, S_LDAR));
      step;
      chk("lda_t4", obs, v(0, 4, 7, 7, S_LDDR));
      step;
      chk("lda_t5", obs, v(0, 5, 2, 0, S_LDAC));
      step;
      chk("lda_end", SC, 0);

      // ISZ with DR reaching zero, then not
      for (int k = 0; k < 2; k++) begin
         DR_Z = (k == 0);
         fetch(16'h6200);
         chk("isz_t3", obs, v(0, 3, 7, 0, 14'h0));
         step;
         chk("isz_t4", obs, v(0, 4, 7, 7, S_LDDR));
         step;
         chk("isz_t5", obs, v(0, 5, 7, 0, S_INCDR));
         step;
         if (k == 0)
            chk("isz_t6_z", obs, v(0, 6, 7, 3, S_MEMWR | S_INCPC));
         else
            chk("isz_t6_nz", obs, v(0, 6, 7, 3, S_MEMWR));
         step;
         chk("isz_end", SC, 0);
      end
      DR_Z = 0;

      // BSA
      fetch(16'h5777);
      step;
      chk("bsa_t4", obs, v(0, 4, 7, 2, S_MEMWR | S_INCAR));
      step;
      chk("bsa_t5", obs, v(0, 5, 7, 1, S_LDPC));
      step;
      chk("bsa_end", SC, 0);

      // Register-reference
      Z = 1;
      rref("cma_sza", 16'h7204, 3'b011, S_LDAC | S_INCPC);
      Z = 0;
      rref("cla", 16'h7800, 3'b111, S_CLRAC);
      fetch(16'h7A00);
      chk("cla_cma", {18'd0, strb}, {18'd0, S_CLRAC});
      step;
      rref("cme_cir", 16'h7180, 3'b100, S_LDAC | S_EEN | S_CMPE);
      rref("cle_cil_inc", 16'h7460, 3'b101,
           S_CLRE | S_LDAC | S_EEN | S_INCAC);
      N = 1;
      rref("sna_n1", 16'h7018, 3'b111, S_INCPC);
      rref("spa_n1", 16'h7010, 3'b111, 14'h0);
      N = 0;
      E = 0;
      rref("sze_e0", 16'h7002, 3'b111, S_INCPC);
      E = 1;
      rref("sze_e1", 16'h7002, 3'b111, 14'h0);
      rref("io_nop", 16'hF800, 3'b111, 14'h0);

      // HLT
      fetch(16'h7001);
      chk("hlt_t3", obs, v(0, 3, 7, 0, 14'h0));
      step;
      IR = 16'h1123;
      chk("halted", obs, v(1, 0, 7, 0, 14'h0));
      for (int k = 0; k < 10; k++) begin
         step;
         chk("halt_hold", obs, v(1, 0, 7, 0, 14'h0));
      end
      RST_N = 1'b0;
      step;
      chk("halt_clr", obs, v(0, 0, 7, 0, 14'h0));
      RST_N = 1'b1;

      // STA, plain then reset at T4
      fetch(16'h3010);
      chk("sta_t3", obs, v(0, 3, 7, 0, 14'h0));
      step;
      chk("sta_t4", obs, v(0, 4, 7, 4, S_MEMWR));
      step;
      chk("sta_end", SC, 0);
      fetch(16'h3010);
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      chk("sta_rst_t4", obs, v(0, 4, 7, 0, 14'h0));
      step;
      chk("sta_rst_sc", obs, v(0, 0, 7, 0, 14'h0));
      RST_N = 1'b1;
      #1;
      chk("refetch", obs, v(0, 0, 7, 2, S_LDAR));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bc_control_unit.md
Name: bc_control_unit

Overview:
- Timing and control sequencer for the basic computer; the producer-side counterpart of the ALU.
- Holds the sequence counter and decodes IR.
- Drives the ALU opcode select (OPSEL), bus select, and every register load/increment/clear strobe.
- Consumes the ALU status flags (Z, N) plus the E and DR_Z datapath flags to resolve skips and ISZ.

Parameters:
ADDR_W, 12, address field width taken from IR[ADDR_W-1:0]; informational, only IR bit positions depend on it.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  reset, synchronous, active-low.
IR  input  16  instruction register contents.
Z  input  1  ALU zero flag.
N  input  1  ALU sign flag.
E  input  1  current E flip-flop.
DR_Z  input  1  high when DR==0.
OPSEL  output  3  ALU operation: 000 ADD, 001 AND, 010 pass DR, 011 complement AC, 100 CIR, 101 CIL, 111 NOP.
BUS_SEL  output  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM.
LD_AR, LD_PC, LD_DR, LD_AC, LD_IR  output  1 each  register load strobes.
INC_AR, INC_PC, INC_DR, INC_AC  output  1 each  register increment strobes.
CLR_AC, CLR_E, CMP_E  output  1 each  clear/complement strobes.
E_EN  output  1  E flip-flop takes the ALU carry-control this cycle.
MEM_WR  output  1  memory write at M[AR].
SC  output  3  sequence counter T-state, for debug.
HALTED  output  1  HLT executed.

Behaviour:
- Sequence and output timing
  - SC is a 3-bit register; T0..T6 map to SC=0..6.
  - All strobes and OPSEL are combinational from SC, the latched I bit, and IR. They are valid during the T-state and take effect at the next rising CLK.
  - Default in every state: OPSEL=111, BUS_SEL=0, all strobes 0.
  - Reset (RST_N=0 at a rising edge): SC=0, I=0, HALTED=0. Reset mid-instruction abandons the instruction; no write is issued in the reset cycle (strobes are forced 0 while RST_N=0).
- Fetch and decode
  - T0: BUS_SEL=2, LD_AR.
  - T1: BUS_SEL=7, LD_IR, INC_PC.
  - T2: BUS_SEL=5, LD_AR (AR<-IR[11:0]); I register <- IR[15].
  - D7 = (IR[14:12]==111).
- T3
  - Memory-reference (D7=0) with I=1: BUS_SEL=7, LD_AR.
  - Memory-reference with I=0: no strobes.
  - Register-reference (D7=1, I=0): execute, then SC<-0.
  - D7=1, I=1 (I/O): not supported; NOP, SC<-0.
- Memory-reference execute, T4 onward; SC<-0 after the last listed step.
  - AND: T4 BUS_SEL=7, LD_DR. T5 OPSEL=001, LD_AC.
  - ADD: T4 read into DR as for AND. T5 OPSEL=000, LD_AC, E_EN.
  - LDA: T4 read into DR. T5 OPSEL=010, LD_AC.
  - STA: T4 BUS_SEL=4, MEM_WR.
  - BUN: T4 BUS_SEL=1, LD_PC.
  - BSA: T4 BUS_SEL=2, MEM_WR, INC_AR. T5 BUS_SEL=1, LD_PC.
  - ISZ: T4 read into DR. T5 INC_DR. T6 BUS_SEL=3, MEM_WR, INC_PC if DR_Z=1.
- Register-reference at T3. Each set IR[11:0] bit acts; multiple bits act simultaneously.
  - Bit 11 CLA: CLR_AC.
  - Bit 10 CLE: CLR_E.
  - Bit 9 CMA: OPSEL=011, LD_AC.
  - Bit 8 CME: CMP_E.
  - Bit 7 CIR: OPSEL=100, LD_AC, E_EN.
  - Bit 6 CIL: OPSEL=101, LD_AC, E_EN.
  - Bit 5 INC: INC_AC.
  - Bit 4 SPA: skip if N=0.
  - Bit 3 SNA: skip if N=1.
  - Bit 2 SZA: skip if Z=1.
  - Bit 1 SZE: skip if E=0.
  - Bit 0 HLT: HALTED<-1.
  - Skip: INC_PC is asserted if any enabled skip condition holds (OR).
  - OPSEL conflict: CMA > CIR > CIL, highest-bit wins. CLA also set with an ALU op: CLR_AC wins, and LD_AC is suppressed.
  - Skip tests use Z/N with OPSEL=111, so they reflect the AC before this cycle's update.
- Halt
  - HALTED is sticky until reset.
  - While HALTED: SC holds 0, all strobes 0, OPSEL=111.
- SC never reaches 7; if it reads 7 it forces SC<-0 with no strobes.

Test Plan:
- Reset then fetch, with RST_N low for 2 cycles -> SC=0, HALTED=0, all strobes 0.
  - After release, T0 gives BUS_SEL=2 and LD_AR; T1 gives BUS_SEL=7, LD_IR, INC_PC; T2 gives BUS_SEL=5 and LD_AR.
- ADD direct, IR=16'h1123 -> T4 BUS_SEL=7 and LD_DR; T5 OPSEL=000, LD_AC, E_EN=1; SC returns to 0 after T5; 6 cycles total.
- LDA indirect, IR=16'hA050 -> T3 BUS_SEL=7 and LD_AR; T5 OPSEL=010 and LD_AC.
- ISZ, IR=16'h6200.
  - DR_Z=1 at T6 -> MEM_WR=1, BUS_SEL=3, INC_PC=1.
  - Repeat with DR_Z=0 -> INC_PC=0.
- Register-reference, IR=16'h7204 (CMA+SZA) with Z=1 -> T3 OPSEL=011, LD_AC, INC_PC; SC=0 next.
  - IR=16'h7800 with CMA also set (16'h7A00) -> CLR_AC=1, LD_AC=0.
- HLT, IR=16'h7001 -> HALTED=1 from the next edge; SC stays 0 for 10 cycles with strobes 0.
  - Pulsing RST_N low clears HALTED; fetch resumes.
  - Reset asserted at T4 of STA -> MEM_WR never pulses; SC=0.
